core_inst_gen: RTL and testbench

- Instruction sequencer that drives the 21-bit `inst` word of one attention core.
- Given a start command and a Q-vector count, it steps through these phases: Q/K SRAM fill, K preload into the MAC array, Q execute, OFIFO drain into PSUM memory, and optionally the normalization pass.
- Sits between the testbench/top-level controller and `core`.
- Requests external vector data one row per cycle while it writes the Q and K memories.

---
 rtl/core_inst_gen_if.sv | 23 ++
 rtl/core_inst_gen.sv | 166 ++++++++++++++++
 tb/tb_core_inst_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_inst_gen_if.sv
// Command/instruction bundle between the top-level controller and the core instruction sequencer.
// master = controller side, slave = sequencer side.
interface core_inst_gen_if;
    logic        start;
    logic [4:0]  n_q;
    logic        stall;
    logic [20:0] inst;
    logic        data_req;
    logic        data_sel;
    logic [3:0]  data_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, n_q, stall,
        input  inst, data_req, data_sel, data_idx, busy, done
    );

    modport slave (
        input  start, n_q, stall,
        output inst, data_req, data_sel, data_idx, busy, done
    );
endinterface

// File: rtl/core_inst_gen.sv
// Instruction sequencer for one attention core: Q/K fill, K preload, Q execute, OFIFO drain.
// Define CORE_INST_GEN_NORM_EN to append the 4-phase per-row normalization pass after the drain.
module core_inst_gen #(
    parameter int col       = 8,
    parameter int MAX_Q     = 16,
    parameter int DRAIN_CYC = 10
) (
    input  logic           clk,
    input  logic           reset,
    core_inst_gen_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, QWR, KWR, KLD, KPAD, EXE, EPAD, DRAIN, OFR, NORM, FIN
    } state_t;

    localparam logic [4:0] MAXQ = 5'(MAX_Q);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] step_len;
    logic [4:0]  nq;
    logic [4:0]  nq_sat;
    logic [3:0]  idx;
    logic        bump;
    logic        last_step;
`ifdef CORE_INST_GEN_NORM_EN
    logic [1:0]  ph;
`endif

    assign nq_sat = (bus.n_q > MAXQ) ? MAXQ : bus.n_q;
    assign idx    = cnt[3:0];

    // Length of the current state and where it goes when its last step issues.
    always_comb begin
        step_len   = 16'd1;
        next_state = FIN;
        case (state)
            QWR:   begin step_len = {11'd0, nq};      next_state = KWR;   end
            KWR:   begin step_len = 16'(col);         next_state = KLD;   end
            KLD:   begin step_len = 16'(col);         next_state = KPAD;  end
            KPAD:  begin step_len = 16'd1;            next_state = EXE;   end
            EXE:   begin step_len = {11'd0, nq};      next_state = EPAD;  end
            EPAD:  begin step_len = 16'd1;            next_state = DRAIN; end
            DRAIN: begin step_len = 16'(DRAIN_CYC);   next_state = OFR;   end
            OFR: begin
                step_len = {11'd0, nq};
`ifdef CORE_INST_GEN_NORM_EN
                next_state = NORM;
`else
                next_state = FIN;
`endif
            end
            NORM:  begin step_len = {11'd0, nq};      next_state = FIN;   end
            default: ;
        endcase
    end

`ifdef CORE_INST_GEN_NORM_EN
    // In NORM the row counter only moves after the fourth phase of a row.
    assign bump = (state != NORM) || (ph == 2'd3);
`else
    assign bump = 1'b1;
`endif
    assign last_step = bump && (cnt == step_len - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            nq           <= '0;
            bus.inst     <= '0;
            bus.data_req <= 1'b0;
            bus.data_sel <= 1'b0;
            bus.data_idx <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef CORE_INST_GEN_NORM_EN
            ph           <= '0;
`endif
        end else begin
            bus.inst     <= '0;
            bus.data_req <= 1'b0;
            bus.data_sel <= 1'b0;
            bus.data_idx <= '0;
            bus.done     <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    nq       <= nq_sat;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= (nq_sat == 5'd0) ? FIN : QWR;
                end
            end else if (!bus.stall) begin
                // A stalled cycle issues nothing and holds state, so the step re-issues intact.
                case (state)
                    QWR: begin
                        bus.inst[4]      <= 1'b1;
                        bus.inst[15:12]  <= idx;
                        bus.data_req     <= 1'b1;
                        bus.data_idx     <= idx;
                    end
                    KWR: begin
                        bus.inst[2]      <= 1'b1;
                        bus.inst[15:12]  <= idx;
                        bus.data_req     <= 1'b1;
                        bus.data_sel     <= 1'b1;
                        bus.data_idx     <= idx;
                    end
                    KLD: begin
                        bus.inst[3]      <= 1'b1;
                        bus.inst[6]      <= 1'b1;
                        bus.inst[15:12]  <= idx;
                    end
                    KPAD: bus.inst[6] <= 1'b1;
                    EXE: begin
                        bus.inst[5]      <= 1'b1;
                        bus.inst[7]      <= 1'b1;
                        bus.inst[15:12]  <= idx;
                    end
                    EPAD: bus.inst[7] <= 1'b1;
                    OFR: begin
                        bus.inst[16]     <= 1'b1;
                        bus.inst[0]      <= 1'b1;
                        bus.inst[11:8]   <= idx;
                    end
`ifdef CORE_INST_GEN_NORM_EN
                    NORM: begin
                        bus.inst[11:8] <= idx;
                        case (ph)
                            2'd0: bus.inst[1]  <= 1'b1;
                            2'd1: bus.inst[18] <= 1'b1;
                            2'd2: begin
                                bus.inst[19] <= 1'b1;
                                bus.inst[17] <= 1'b1;
                            end
                            default: begin
                                bus.inst[20] <= 1'b1;
                                bus.inst[0]  <= 1'b1;
                            end
                        endcase
                    end
`endif
                    FIN: begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                    default: ;
                endcase

                if (state == FIN) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (last_step) begin
                    state <= next_state;
                    cnt   <= '0;
                end else if (bump) begin
                    cnt <= cnt + 16'd1;
                end
`ifdef CORE_INST_GEN_NORM_EN
                ph <= (state == NORM) ? ph + 2'd1 : 2'd0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_core_inst_gen.sv
// Randomized self-checking bench for core_inst_gen: a step-list reference model is compared every cycle,
// plus literal busy-length and instruction pins for the directed runs.
module tb_core_inst_gen;
    localparam int COL   = 8;
    localparam int MAXQ  = 16;
    localparam int DRAIN = 10;
`ifdef CORE_INST_GEN_NORM_EN
    localparam int NORM_ROW = 4;
`else
    localparam int NORM_ROW = 0;
`endif

    typedef struct {
        logic [20:0] inst;
        logic        req;
        logic        sel;
        logic [3:0]  idx;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    core_inst_gen_if bus ();

    core_inst_gen #(.col(COL), .MAX_Q(MAXQ), .DRAIN_CYC(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    step_t       exp_q[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [20:0] m_inst = '0;
    logic        m_req  = 1'b0;
    logic        m_sel  = 1'b0;
    logic [3:0]  m_idx  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input int inst, input bit req, input bit sel, input int idx);
        step_t s;
        s.inst = 21'(inst);
        s.req  = req;
        s.sel  = sel;
        s.idx  = 4'(idx);
        exp_q.push_back(s);
    endtask

    // Full list of instruction steps a sequence of nq Q vectors must issue, in order.
    task automatic build(input int nq);
        exp_q.delete();
        if (nq == 0) return;
        for (int i = 0; i < nq; i++)    push((1 << 4) | (i << 12), 1, 0, i);
        for (int i = 0; i < COL; i++)   push((1 << 2) | (i << 12), 1, 1, i);
        for (int i = 0; i < COL; i++)   push((1 << 3) | (1 << 6) | (i << 12), 0, 0, 0);
        push(1 << 6, 0, 0, 0);
        for (int i = 0; i < nq; i++)    push((1 << 5) | (1 << 7) | (i << 12), 0, 0, 0);
        push(1 << 7, 0, 0, 0);
        for (int i = 0; i < DRAIN; i++) push(0, 0, 0, 0);
        for (int i = 0; i < nq; i++)    push((1 << 16) | 1 | (i << 8), 0, 0, 0);
        if (NORM_ROW != 0) begin
            for (int r = 0; r < nq; r++) begin
                push((1 << 1) | (r << 8), 0, 0, 0);
                push((1 << 18) | (r << 8), 0, 0, 0);
                push((1 << 19) | (1 << 17) | (r << 8), 0, 0, 0);
                push((1 << 20) | 1 | (r << 8), 0, 0, 0);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                exp_q.delete();
                m_busy = 1'b0; m_done = 1'b0; m_inst = '0;
                m_req = 1'b0; m_sel = 1'b0; m_idx = '0;
            end else begin
                step_t s;
                m_done = 1'b0; m_inst = '0; m_req = 1'b0; m_sel = 1'b0; m_idx = '0;
                if (!m_busy) begin
                    if (bus.start) begin
                        build((int'(bus.n_q) > MAXQ) ? MAXQ : int'(bus.n_q));
                        m_busy = 1'b1;
                    end
                end else if (bus.stall) begin
                    // stalled: nothing issued this cycle
                end else if (exp_q.size() > 0) begin
                    s = exp_q.pop_front();
                    m_inst = s.inst; m_req = s.req; m_sel = s.sel; m_idx = s.idx;
                end else begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("inst", bus.inst, m_inst);
                check("data_req", bus.data_req, m_req);
                check("busy", bus.busy, m_busy);
                check("done", bus.done, m_done);
                if (m_req) begin
                    check("data_sel", bus.data_sel, m_sel);
                    check("data_idx", bus.data_idx, m_idx);
                end
            end
        end
    end

    task automatic run_seq(input int nq, input int st_at, input int st_len, input int extra_k,
                           input bit stall_start, input bit rnd_stall, input int exp_busy, input bit pin);
        int busy_n = 0;
        int done_n = 0;
        bit fin = 1'b0;
        @(negedge clk);
        bus.n_q   = 5'(nq);
        bus.start = 1'b1;
        bus.stall = stall_start;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.n_q   = 5'($urandom);
        if (bus.busy) busy_n++;
        for (int k = 1; k <= 600 && !fin; k++) begin
            bus.stall = rnd_stall ? ($urandom_range(0, 5) == 0) : (k >= st_at && k < st_at + st_len);
            bus.start = (k == extra_k);
            @(posedge clk);
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin done_n++; fin = 1'b1; end
            if (pin) begin
                if (k == 1)  check("pin_qwr0", bus.inst, 21'h000010);
                if (k == 21) check("pin_kpad", bus.inst, 21'h000040);
                if (k == 26) check("pin_epad", bus.inst, 21'h000080);
                if (k == 37) check("pin_ofr0", bus.inst, 21'h010001);
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        if (!fin) begin
            n_fail++;
            $display("FAIL timeout: done not seen within 600 cycles, busy count %0d", busy_n);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        check("done_once", done_n, 1);
        if (exp_busy >= 0) check("busy_len", busy_n, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.n_q   = '0;
        bus.stall = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_inst", bus.inst, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_req", bus.data_req, 0);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(4, 0, 0, 0, 0, 0, 41 + 4 * NORM_ROW, 1);
        run_seq(20, 0, 0, 0, 0, 0, 77 + 16 * NORM_ROW, 0);
        run_seq(4, 24, 3, 0, 0, 0, 44 + 4 * NORM_ROW, 0);
        run_seq(4, 0, 0, 5, 0, 0, 41 + 4 * NORM_ROW, 0);
        run_seq(0, 0, 0, 0, 0, 0, 1, 0);
        run_seq(3, 0, 0, 0, 1, 0, 38 + 3 * NORM_ROW, 0);
        run_seq(2, 0, 0, 0, 0, 0, 35 + 2 * NORM_ROW, 0);

        // Asynchronous abort in the middle of the K preload
        @(negedge clk);
        bus.n_q = 5'd4;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_inst", bus.inst, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end
        run_seq(4, 0, 0, 0, 0, 0, 41 + 4 * NORM_ROW, 0);

        for (int r = 0; r < 12; r++) begin
            run_seq(int'($urandom_range(0, 22)), 0, 0, int'($urandom_range(0, 12)),
                    1'($urandom_range(0, 1)), 1'b1, -1, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
